cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
Fetch/decode/execute sequencer for the 16-bit Von Neumann processor; sits directly upstream of the combinational ALU.
- Fetches instructions and data over one shared memory port.
- Holds the 4-entry register file, drives the ALU operands and opcode, and writes the ALU result back.
- Handles load, store, jump and halt itself; all arithmetic and logic is done by the ALU.

Parameters:
DATA_W, 16, datapath and instruction width
ADDR_W, 8, memory address width; the PC is this wide
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
mem_req  output  1  memory request; held until mem_ack
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  store data
mem_rdata  input  DATA_W  read data; valid in the mem_ack cycle
mem_ack  input  1  one-cycle transfer-complete strobe
alu_a  output  DATA_W  ALU operand 1 = R[rd]
alu_b  output  DATA_W  ALU operand 2 = R[rs]
alu_op  output  4  ALU opcode
alu_result  input  DATA_W  combinational ALU result
pc  output  ADDR_W  current program counter
halted  output  1  high in HALT state

Behaviour:
- Instruction fields: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/addr.
- Opcodes 0001–0110 are ALU ops with R[rd] <= R[rd] op R[rs]:
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 CLR.
- Other opcodes:
  - 0000 NOP.
  - 0111 LOAD: R[rd] <= M[imm].
  - 1000 STORE: M[imm] <= R[rs].
  - 1001 JMP: pc <= imm.
  - 1010 JZ (optional feature).
  - 1111 HALT.
  - 1011–1110 execute as NOP.
- Reset values: pc=RESET_PC, registers R0–R3=0, IR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_a=0, alu_b=0, alu_op=0, halted=0, state=FETCH.
- Reset takes priority over every transition. Reset during a pending memory request drops mem_req on the next edge; a late mem_ack is ignored.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack: IR <= mem_rdata, pc <= pc+1 (wraps mod 2^ADDR_W), go to DECODE.
- DECODE (1 cycle):
  - ALU op: alu_a <= R[rd], alu_b <= R[rs], alu_op <= opcode; go to EXEC.
  - LOAD/STORE: go to MEM.
  - JMP: pc <= imm; go to FETCH.
  - NOP or undefined: go to FETCH.
  - HALT: go to HALT.
- EXEC (1 cycle): R[rd] <= alu_result; go to FETCH.
- MEM:
  - mem_req=1, mem_addr=imm, mem_we=(opcode==STORE), mem_wdata=R[rs].
  - On mem_ack: for LOAD, R[rd] <= mem_rdata; go to FETCH.
- HALT: absorbing state until rst. halted=1; mem_req=0.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable until the ack cycle.
  - mem_req deasserts in the cycle after mem_ack; there are no back-to-back requests without one idle cycle.
  - mem_ack while mem_req=0 is ignored.
- Latency with a same-cycle ack (ack in the first cycle mem_req is high):
  - ALU op: 4 cycles.
  - LOAD/STORE: 6 cycles.
  - JMP/NOP: 3 cycles.
- Memory wait states add one cycle each.
- Arithmetic is modulo 2^DATA_W; overflow is ignored.
- When rd == rs, the ALU reads the same register twice (for example, XOR clears it).
- alu_a, alu_b and alu_op keep their last values outside EXEC.

Optional Feature:
- Macro: CU_BRANCH_EN.
- Defined:
  - A 1-bit zero flag Z, reset 0, is updated on EXEC writeback and LOAD writeback: Z = (written value == 0).
  - JZ (1010): in DECODE, if Z=1 then pc <= imm; go to FETCH either way.
- Undefined: no Z flag is built, and 1010 executes as NOP.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams (OP_NOP … OP_HALT);
  - the state encoding;
  - instruction field bit positions;
  - NUM_REGS=4.
- Sub-module cu_reg_file: 4×DATA_W registers, 2 combinational read ports, 1 synchronous write port, synchronous reset to 0.

Test Plan:
- Reset then ALU op, same-cycle-ack memory model:
  - Stimulus: M[0]=LOAD R1,[0x10]; M[1]=LOAD R2,[0x11]; M[2]=ADD R1,R2; M[3]=STORE R1,[0x12]; M[4]=HALT; M[0x10]=0x0005, M[0x11]=0x0003.
  - Required: M[0x12]=0x0008, halted=1, pc=5.
- Wraparound: R1=0xFFFF, R2=0x0001, ADD R1,R2 → R1=0x0000. SUB with R1=0, R2=1 → R1=0xFFFF.
- Wait states: ack delayed 3 cycles on every access → same architectural result. mem_req, mem_addr and mem_we hold stable for all 3 wait cycles, and mem_req drops in the cycle after ack.
- Control flow:
  - JMP 0x20 at address 0 → next fetch address is 0x20.
  - Fetch from pc=0xFF → pc wraps to 0x00.
  - Undefined opcode 1100 → behaves as NOP, with pc advanced by 1 and no register changes.
- Reset mid-transaction: assert rst during a MEM wait cycle → next cycle mem_req=0, pc=RESET_PC, all registers 0, and a late ack is ignored.
- CU_BRANCH_EN defined:
  - CLR R0 then JZ 0x30 → branch taken, fetch from 0x30.
  - With R0 nonzero → not taken.
  - CU_BRANCH_EN undefined: JZ is a NOP.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the cpu_control_unit sequencer: opcodes, FSM states,
// instruction field positions and register-file geometry.
package cu_pkg;

  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;
  localparam int OP_W     = 4;

  // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/addr
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h2;
  localparam logic [OP_W-1:0] OP_AND   = 4'h3;
  localparam logic [OP_W-1:0] OP_OR    = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h5;
  localparam logic [OP_W-1:0] OP_CLR   = 4'h6;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h7;
  localparam logic [OP_W-1:0] OP_STORE = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP   = 4'h9;
  localparam logic [OP_W-1:0] OP_JZ    = 4'hA;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CLR};
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Shared instruction/data memory port: the control unit is the master,
// the memory (or its model) is the slave.
interface cpu_control_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cu_reg_file.sv
// Four-entry architectural register file: two combinational read ports,
// one synchronous write port, synchronous active-high reset.
module cu_reg_file
  import cu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // NOTE: this array is reset because the ISA defines R0-R3 = 0 after reset;
  // a large RAM-style array would normally be left unreset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit Von Neumann CPU.
// Optional JZ branch with zero flag is built when CU_BRANCH_EN is defined.
module cpu_control_unit
  import cu_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  cpu_control_unit_if.master  mem,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_done;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_halted;
`ifdef CU_BRANCH_EN
  logic              r_z;
`endif

  logic [OP_W-1:0]   w_opcode;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs;
  logic [ADDR_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_rs_data;
  logic              w_rf_we;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_ack;

  assign w_opcode = r_ir[OPC_MSB:OPC_LSB];
  assign w_rd     = r_ir[RD_MSB:RD_LSB];
  assign w_rs     = r_ir[RS_MSB:RS_LSB];
  assign w_imm    = ADDR_W'(r_ir[IMM_MSB:IMM_LSB]);
  // An ack only counts while our own request is outstanding.
  assign w_ack    = r_mem_req & mem.mem_ack;

  // NOTE: every signal gets a default before the conditions so no latch is inferred.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wdata = alu_result;
    if (r_state == S_EXEC) begin
      w_rf_we = 1'b1;
    end else if (r_state == S_MEM && w_ack && w_opcode == OP_LOAD) begin
      w_rf_we    = 1'b1;
      w_rf_wdata = mem.mem_rdata;
    end
  end

  cu_reg_file #(.DATA_W(DATA_W)) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_rd),
    .i_raddr_b (w_rs),
    .o_rdata_a (w_rd_data),
    .o_rdata_b (w_rs_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_done  <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_halted    <= 1'b0;
`ifdef CU_BRANCH_EN
      r_z         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          // First cycle issues the request; the idle cycle before it separates transfers.
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_ir      <= mem.mem_rdata;
            r_pc      <= r_pc + ADDR_W'(1);
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_alu_op(w_opcode)) begin
            r_alu_a  <= w_rd_data;
            r_alu_b  <= w_rs_data;
            r_alu_op <= w_opcode;
            r_state  <= S_EXEC;
          end else begin
            case (w_opcode)
              OP_LOAD, OP_STORE: r_state <= S_MEM;
              OP_JMP: begin
                r_pc    <= w_imm;
                r_state <= S_FETCH;
              end
`ifdef CU_BRANCH_EN
              OP_JZ: begin
                if (r_z) r_pc <= w_imm;
                r_state <= S_FETCH;
              end
`else
              OP_JZ:   r_state <= S_FETCH;
`endif
              OP_HALT: begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end
              OP_NOP:  r_state <= S_FETCH;
              default: r_state <= S_FETCH;
            endcase
          end
        end
        S_EXEC: begin
`ifdef CU_BRANCH_EN
          r_z <= (alu_result == '0);
`endif
          r_state <= S_FETCH;
        end
        S_MEM: begin
          // Setup cycle, request cycle(s) until ack, then one release cycle.
          if (r_mem_done) begin
            r_mem_done <= 1'b0;
            r_state    <= S_FETCH;
          end else if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_opcode == OP_STORE);
            r_mem_addr  <= w_imm;
            r_mem_wdata <= w_rs_data;
          end else if (mem.mem_ack) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_done <= 1'b1;
`ifdef CU_BRANCH_EN
            if (w_opcode == OP_LOAD) r_z <= (mem.mem_rdata == '0);
`endif
          end
        end
        S_HALT: begin
          r_halted  <= 1'b1;
          r_mem_req <= 1'b0;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign pc            = r_pc;
  assign halted        = r_halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench: memory and ALU models plus an instruction-level
// reference interpreter that predicts memory, pc, access order and cycle count.
module tb_cpu_control_unit;
  import cu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_control_unit_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic [AW-1:0] pc;
  logic          halted;

  cpu_control_unit #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem_if),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .pc         (pc),
    .halted     (halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  function automatic logic [15:0] ins(input logic [3:0] op, input int rd, input int rs, input int imm);
    return {op, 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  // ---------------- memory model with wait states and handshake monitor
  logic [15:0] mem_arr [256];
  int          wait_n = 0;
  int          wcnt = 0;
  int          hs_err = 0;
  bit          stray_ack = 0;
  bit          prev_req = 0, prev_acked = 0, prev_we = 0;
  logic [7:0]  prev_addr = '0;
  logic [24:0] dut_trace [$];

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
  end

  always begin
    @(posedge clk);
    #1;
    if (stray_ack && !mem_if.mem_req) begin
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = 16'hF000;
      stray_ack = 0; wcnt = 0; prev_req = 0; prev_acked = 0;
    end else if (rst) begin
      mem_if.mem_ack = 1'b0;
      wcnt = 0; prev_req = 0; prev_acked = 0;
    end else begin
      mem_if.mem_ack = 1'b0;
      if (prev_acked && mem_if.mem_req) hs_err++;
      if (prev_req && !prev_acked) begin
        if (!mem_if.mem_req) hs_err++;
        else if (mem_if.mem_addr !== prev_addr || mem_if.mem_we !== prev_we) hs_err++;
      end
      prev_acked = 0;
      if (mem_if.mem_req) begin
        if (wcnt == wait_n) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem_arr[mem_if.mem_addr];
          if (mem_if.mem_we) mem_arr[mem_if.mem_addr] = mem_if.mem_wdata;
          dut_trace.push_back({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_we ? mem_if.mem_wdata : 16'h0});
          wcnt = 0;
          prev_acked = 1;
        end else begin
          wcnt++;
        end
      end
      prev_req  = mem_if.mem_req;
      prev_addr = mem_if.mem_addr;
      prev_we   = mem_if.mem_we;
    end
  end

  // ---------------- instruction-level reference interpreter
  logic [15:0] ref_mem [256];
  logic [15:0] ref_reg [4];
  logic [7:0]  ref_pc;
  bit          ref_z;
  int          exp_cyc;
  logic [24:0] exp_trace [$];

  task automatic model_run(input int w);
    ref_pc = 8'h00; ref_z = 0; exp_cyc = 0;
    exp_trace.delete();
    for (int i = 0; i < 4; i++) ref_reg[i] = 16'h0;
    for (int step = 0; step < 1000; step++) begin
      logic [15:0] ir;
      logic [3:0]  op;
      int          rd, rs;
      logic [7:0]  imm;
      ir = ref_mem[ref_pc];
      exp_trace.push_back({1'b0, ref_pc, 16'h0});
      ref_pc = ref_pc + 8'd1;
      op = ir[15:12]; rd = int'(ir[11:10]); rs = int'(ir[9:8]); imm = ir[7:0];
      if (op >= 4'd1 && op <= 4'd6) begin
        ref_reg[rd] = alu_fn(op, ref_reg[rd], ref_reg[rs]);
        ref_z = (ref_reg[rd] == 16'h0);
        exp_cyc += 4 + w;
      end else if (op == 4'd7) begin
        exp_trace.push_back({1'b0, imm, 16'h0});
        ref_reg[rd] = ref_mem[imm];
        ref_z = (ref_reg[rd] == 16'h0);
        exp_cyc += 6 + 2 * w;
      end else if (op == 4'd8) begin
        exp_trace.push_back({1'b1, imm, ref_reg[rs]});
        ref_mem[imm] = ref_reg[rs];
        exp_cyc += 6 + 2 * w;
      end else if (op == 4'd9) begin
        ref_pc = imm;
        exp_cyc += 3 + w;
      end else if (op == 4'hA) begin
`ifdef CU_BRANCH_EN
        if (ref_z) ref_pc = imm;
`endif
        exp_cyc += 3 + w;
      end else if (op == 4'hF) begin
        exp_cyc += 3 + w;
        return;
      end else begin
        exp_cyc += 3 + w;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
  endtask

  task automatic prep(input int w);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
    model_run(w);
    wait_n = w;
    hs_err = 0;
    dut_trace.delete();
  endtask

  task automatic finish(input string tag);
    int cyc = 0;
    int d = 0;
    int n;
    while (halted !== 1'b1 && cyc < 5000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    check({tag, ".halted"}, halted, 1);
    check({tag, ".cycles"}, cyc, exp_cyc);
    check({tag, ".pc"}, pc, ref_pc);
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) d++;
    check({tag, ".mem_diffs"}, d, 0);
    check({tag, ".trace_len"}, dut_trace.size(), exp_trace.size());
    n = (dut_trace.size() < exp_trace.size()) ? dut_trace.size() : exp_trace.size();
    d = 0;
    for (int i = 0; i < n; i++) if (dut_trace[i] !== exp_trace[i]) d++;
    check({tag, ".trace_diffs"}, d, 0);
    repeat (3) @(negedge clk);
    check({tag, ".halt_idle"}, {halted, mem_if.mem_req}, 2'b10);
    check({tag, ".handshake"}, hs_err, 0);
  endtask

  task automatic run_prog(input int w, input string tag);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    prep(w);
    rst = 1'b0;
    finish(tag);
  endtask

  task automatic basic_prog();
    clear_mem();
    mem_arr[0] = ins(OP_LOAD, 1, 0, 8'h10);
    mem_arr[1] = ins(OP_LOAD, 2, 0, 8'h11);
    mem_arr[2] = ins(OP_ADD, 1, 2, 0);
    mem_arr[3] = ins(OP_STORE, 0, 1, 8'h12);
    mem_arr[4] = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'h10] = 16'h0005;
    mem_arr[8'h11] = 16'h0003;
  endtask

  initial begin
    logic [24:0] t;
    int cnt;

    clear_mem();
    repeat (2) @(negedge clk);
    check("reset.pc", pc, 8'h00);
    check("reset.req_we", {mem_if.mem_req, mem_if.mem_we}, 2'b00);
    check("reset.halted", halted, 0);
    check("reset.alu", {alu_op, alu_a, alu_b}, 36'h0);

    basic_prog();
    run_prog(0, "basic");
    check("basic.m12", mem_arr[8'h12], 16'h0008);
    check("basic.pc5", pc, 8'h05);

    basic_prog();
    run_prog(3, "wait3");
    check("wait3.m12", mem_arr[8'h12], 16'h0008);

    clear_mem();
    mem_arr[0] = ins(OP_LOAD, 1, 0, 8'h10);
    mem_arr[1] = ins(OP_LOAD, 2, 0, 8'h11);
    mem_arr[2] = ins(OP_ADD, 1, 2, 0);
    mem_arr[3] = ins(OP_STORE, 0, 1, 8'h12);
    mem_arr[4] = ins(OP_SUB, 1, 2, 0);
    mem_arr[5] = ins(OP_STORE, 0, 1, 8'h13);
    mem_arr[6] = ins(OP_XOR, 1, 1, 0);
    mem_arr[7] = ins(OP_STORE, 0, 1, 8'h14);
    mem_arr[8] = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'h10] = 16'hFFFF;
    mem_arr[8'h11] = 16'h0001;
    mem_arr[8'h14] = 16'h5A5A;
    run_prog(1, "wrap");
    check("wrap.add", mem_arr[8'h12], 16'h0000);
    check("wrap.sub", mem_arr[8'h13], 16'hFFFF);
    check("wrap.xor_self", mem_arr[8'h14], 16'h0000);

    clear_mem();
    mem_arr[0]     = ins(OP_JMP, 0, 0, 8'h20);
    mem_arr[8'h20] = ins(OP_HALT, 0, 0, 0);
    run_prog(0, "jmp");
    t = (dut_trace.size() > 1) ? dut_trace[1] : '1;
    check("jmp.fetch_addr", t[23:16], 8'h20);

    // Jump to 0xFE, overwrite address 0 with a NOP at 0xFF, then wrap to 0x00.
    clear_mem();
    mem_arr[0]     = ins(OP_JMP, 0, 0, 8'hFE);
    mem_arr[1]     = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'hFE] = ins(OP_NOP, 0, 0, 0);
    mem_arr[8'hFF] = ins(OP_STORE, 0, 0, 8'h00);
    run_prog(0, "pcwrap");
    check("pcwrap.pc", pc, 8'h02);

    clear_mem();
    mem_arr[0] = ins(OP_LOAD, 1, 0, 8'h10);
    mem_arr[1] = ins(4'hB, 1, 2, 8'h33);
    mem_arr[2] = ins(4'hC, 1, 1, 8'h10);
    mem_arr[3] = ins(4'hD, 2, 3, 8'hFF);
    mem_arr[4] = ins(4'hE, 0, 1, 8'h01);
    for (int r = 0; r < 4; r++) mem_arr[5 + r] = ins(OP_STORE, 0, r, 8'hA0 + r);
    mem_arr[9] = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'h10] = 16'hBEEF;
    run_prog(2, "undef");
    check("undef.r1", mem_arr[8'hA1], 16'hBEEF);

    clear_mem();
    mem_arr[0]     = ins(OP_CLR, 0, 0, 0);
    mem_arr[1]     = ins(OP_JZ, 0, 0, 8'h30);
    mem_arr[2]     = ins(OP_STORE, 0, 3, 8'h50);
    mem_arr[3]     = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'h30] = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'h50] = 16'h1234;
    run_prog(0, "jz_zero");
`ifdef CU_BRANCH_EN
    check("jz_zero.taken_pc", pc, 8'h31);
    check("jz_zero.m50", mem_arr[8'h50], 16'h1234);
`else
    check("jz_zero.nop_pc", pc, 8'h04);
    check("jz_zero.m50", mem_arr[8'h50], 16'h0000);
`endif

    clear_mem();
    mem_arr[0]     = ins(OP_LOAD, 0, 0, 8'h10);
    mem_arr[1]     = ins(OP_JZ, 0, 0, 8'h30);
    mem_arr[2]     = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'h30] = ins(OP_HALT, 0, 0, 0);
    mem_arr[8'h10] = 16'h0007;
    run_prog(0, "jz_nonzero");
    check("jz_nonzero.pc", pc, 8'h03);

    // Reset while a LOAD is waiting for its ack, followed by a stray ack.
    clear_mem();
    for (int r = 0; r < 4; r++) begin
      mem_arr[r]         = ins(OP_LOAD, (r + 1) % 4, 0, 8'h10 + r);
      mem_arr[8'h10 + r] = 16'(r + 1);
    end
    mem_arr[4] = ins(OP_HALT, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    wait_n = 3;
    rst = 1'b0;
    cnt = 0;
    while (!(mem_if.mem_req && mem_if.mem_addr == 8'h13 && !mem_if.mem_we) && cnt < 500) begin
      @(negedge clk); cnt++;
    end
    check("rstmid.reached", cnt < 500, 1);
    @(negedge clk);
    rst = 1'b1;
    stray_ack = 1;
    @(negedge clk);
    check("rstmid.req", mem_if.mem_req, 0);
    check("rstmid.pc", pc, 8'h00);
    check("rstmid.halted", halted, 0);
    clear_mem();
    for (int r = 0; r < 4; r++) begin
      mem_arr[r]         = ins(OP_STORE, 0, r, 8'hA0 + r);
      mem_arr[8'hA0 + r] = 16'h5555;
    end
    mem_arr[4] = ins(OP_HALT, 0, 0, 0);
    prep(0);
    rst = 1'b0;
    finish("rstmid");
    check("rstmid.stray_used", stray_ack, 0);

    for (int p = 0; p < 10; p++) begin
      clear_mem();
      for (int i = 0; i < 20; i++) begin
        logic [3:0] op;
        int imm;
        op  = 4'($urandom_range(0, 15));
        imm = $urandom_range(0, 255);
        if (op == OP_LOAD)  imm = 8'h80 + $urandom_range(0, 15);
        if (op == OP_STORE) imm = 8'h90 + $urandom_range(0, 15);
        if (op == OP_JMP || op == OP_JZ) imm = i + 1 + $urandom_range(0, 2);
        if (op == OP_HALT)  op = OP_NOP;
        mem_arr[i] = ins(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
      end
      for (int r = 0; r < 4; r++) mem_arr[20 + r] = ins(OP_STORE, 0, r, 8'hB0 + r);
      mem_arr[24] = ins(OP_HALT, 0, 0, 0);
      for (int i = 8'h80; i < 8'h90; i++) mem_arr[i] = 16'($urandom_range(0, 65535));
      mem_arr[8'h80] = 16'h0000;
      run_prog($urandom_range(0, 3), $sformatf("rand%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
